// File: rtl/quiz_pkg.sv
// quiz_pkg: shared FSM state encoding, default cycle constants and a
// counter-width helper for the quiz buzzer arbiter.
package quiz_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_LOCKED = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int DEF_N_PLAYERS     = 4;
   localparam int DEF_BUZZ_CYCLES   = 25_000_000;   // 0.5 s at 50 MHz
   localparam int DEF_ANSWER_CYCLES = 500_000_000;  // 10 s at 50 MHz

   // Width needed to hold 0..max_count-1, never narrower than one bit.
   function automatic int cnt_width(input int max_count);
      return (max_count > 1) ? $clog2(max_count) : 1;
   endfunction

endpackage

// File: rtl/quiz_buzzer_arbiter_key_sync.sv
// key_sync: W-bit two-flop synchroniser for asynchronous active-low keys.
// Both stages reset to all-ones so no key appears pressed out of reset.
module key_sync #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_async,
   output logic [W-1:0] o_sync
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   // Two-stage capture of the raw key pins into the clock domain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/quiz_buzzer_arbiter.sv
// quiz_buzzer_arbiter: N-player quiz buzzer arbiter.
// Synchronises the active-low player keys, locks the first eligible press
// (lowest index wins ties), drives winner LED/number, a fixed-length buzzer
// pulse and an answer-window countdown ending in a one-cycle timeout pulse.
// Optional feature macro: FOUL_DETECT_EN -- presses while IDLE with Start=0
// set sticky per-player Foul flags and make that player ineligible.
module quiz_buzzer_arbiter
   import quiz_pkg::*;
#(
   parameter  int N_PLAYERS     = DEF_N_PLAYERS,
   parameter  int BUZZ_CYCLES   = DEF_BUZZ_CYCLES,
   parameter  int ANSWER_CYCLES = DEF_ANSWER_CYCLES,
   localparam int PN_W          = $clog2(N_PLAYERS + 1)
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 Start,
   input  logic                 Clear,
   input  logic [N_PLAYERS-1:0] K,
   output logic [N_PLAYERS-1:0] LED_Out,
   output logic [PN_W-1:0]      Player_Number,
   output logic                 Buzzer_Answer,
   output logic                 Timer_Start,
   output logic                 Answer_Timeout,
   output logic [N_PLAYERS-1:0] Foul
);

   localparam int            BW        = cnt_width(BUZZ_CYCLES);
   localparam int            AW        = cnt_width(ANSWER_CYCLES);
   localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_CYCLES - 1);
   localparam logic [AW-1:0] ANS_LOAD  = AW'(ANSWER_CYCLES - 1);

   state_t                 r_state;
   logic [N_PLAYERS-1:0]   r_led;
   logic [PN_W-1:0]        r_pn;
   logic                   r_buzz;
   logic                   r_timer;
   logic                   r_timeout;
   logic [BW-1:0]          r_buzz_cnt;
   logic [AW-1:0]          r_ans_cnt;

   logic [N_PLAYERS-1:0]   w_key_n;
   logic [N_PLAYERS-1:0]   w_pressed;
   logic [N_PLAYERS-1:0]   w_eligible;
   logic [N_PLAYERS-1:0]   w_win_onehot;
   logic [PN_W-1:0]        w_win_num;
   logic                   w_any;

   key_sync #(
      .W (N_PLAYERS)
   ) u_key_sync (
      .i_clk   (CLK),
      .i_rst_n (RSTn),
      .i_async (K),
      .o_sync  (w_key_n)
   );

   assign w_pressed = ~w_key_n;

`ifdef FOUL_DETECT_EN
   logic [N_PLAYERS-1:0] r_foul;
   assign w_eligible = w_pressed & ~r_foul;
   assign Foul       = r_foul;
`else
   assign w_eligible = w_pressed;
   assign Foul       = '0;
`endif

   // Lowest-index priority encoder over the eligible pressed keys.
   always_comb begin
      w_any        = 1'b0;
      w_win_onehot = '0;
      w_win_num    = '0;
      for (int unsigned i = 0; i < N_PLAYERS; i++) begin
         if (w_eligible[i] && !w_any) begin
            w_any           = 1'b1;
            w_win_onehot[i] = 1'b1;
            w_win_num       = PN_W'(i + 1);
         end
      end
   end

   // Round FSM with registered outputs, buzzer and answer-window counters.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state    <= ST_IDLE;
         r_led      <= '0;
         r_pn       <= '0;
         r_buzz     <= 1'b0;
         r_timer    <= 1'b0;
         r_timeout  <= 1'b0;
         r_buzz_cnt <= '0;
         r_ans_cnt  <= '0;
`ifdef FOUL_DETECT_EN
         r_foul     <= '0;
`endif
      end else if (Clear) begin
         r_state    <= ST_IDLE;
         r_led      <= '0;
         r_pn       <= '0;
         r_buzz     <= 1'b0;
         r_timer    <= 1'b0;
         r_timeout  <= 1'b0;
         r_buzz_cnt <= '0;
         r_ans_cnt  <= '0;
`ifdef FOUL_DETECT_EN
         r_foul     <= '0;
`endif
      end else begin
         r_timeout <= 1'b0;

         // Buzzer runs independently of the answer window once started.
         if (r_buzz) begin
            if (r_buzz_cnt == BUZZ_LAST) begin
               r_buzz <= 1'b0;
            end else begin
               r_buzz_cnt <= r_buzz_cnt + BW'(1);
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (Start) begin
                  r_state <= ST_ARMED;
               end
`ifdef FOUL_DETECT_EN
               else begin
                  r_foul <= r_foul | w_pressed;
               end
`endif
            end

            ST_ARMED: begin
               if (!Start) begin
                  r_state <= ST_IDLE;
               end else if (w_any) begin
                  r_state    <= ST_LOCKED;
                  r_led      <= w_win_onehot;
                  r_pn       <= w_win_num;
                  r_timer    <= 1'b1;
                  r_buzz     <= 1'b1;
                  r_buzz_cnt <= '0;
                  r_ans_cnt  <= ANS_LOAD;
               end
            end

            ST_LOCKED: begin
               if (r_ans_cnt == '0) begin
                  r_timeout <= 1'b1;
                  r_timer   <= 1'b0;
                  r_state   <= ST_DONE;
               end else begin
                  r_ans_cnt <= r_ans_cnt - AW'(1);
               end
            end

            ST_DONE: begin
               r_state <= ST_DONE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign LED_Out        = r_led;
   assign Player_Number  = r_pn;
   assign Buzzer_Answer  = r_buzz;
   assign Timer_Start    = r_timer;
   assign Answer_Timeout = r_timeout;

endmodule
